// File: rtl/timer_top_if.sv
// APB slave bus bundle for the timer: handshake, address/data and response lines.
interface timer_top_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  PSEL;
    logic                  PWRITE;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PWRITE, PENABLE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PWRITE, PENABLE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/timer_top.sv
// 8-bit programmable up/down timer with prescaler, reload register and sticky
// wrap flags, controlled through a zero-wait-state APB slave.
module timer_top #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic       PCLK,
    input  logic       PRESET,
    timer_top_if.slave apb,
    output logic       TMR_OVF,
    output logic       TMR_URF
);
    localparam logic [DATA_WIDTH-1:0] TCR_MASK = DATA_WIDTH'(8'hB3);
    localparam int TCR_LOAD = 7;
    localparam int TCR_DIR  = 5;
    localparam int TCR_EN   = 4;

    typedef enum logic [1:0] {
        REG_TDR  = 2'd0,
        REG_TCR  = 2'd1,
        REG_TSR  = 2'd2,
        REG_TCNT = 2'd3
    } reg_sel_e;

    logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
    logic [DATA_WIDTH-1:0] tcr_q, tcr_d;
    logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                  tsr_ovf_q, tsr_ovf_d;
    logic                  tsr_udf_q, tsr_udf_d;
    logic [3:0]            presc_q, presc_d;
    logic [3:0]            presc_prev_q, presc_prev_d;
    logic                  load_prev_q, load_prev_d;

    logic                  addr_hit;
    reg_sel_e              reg_sel;
    logic                  wr_en;
    logic                  tdr_wr, tcr_wr, tsr_wr;
    logic                  load_req;
    logic                  tick;
    logic                  count_go;
    logic                  ovf_set, udf_set;
    logic [1:0]            tsr_clr;
    logic [DATA_WIDTH-1:0] rd_data;

    assign apb.PREADY = 1'b1;

    always_comb begin
        addr_hit = (apb.PADDR[ADDR_WIDTH-1:2] == '0);
        reg_sel  = reg_sel_e'(apb.PADDR[1:0]);
        wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE & apb.PREADY;
        tdr_wr   = wr_en & addr_hit & (reg_sel == REG_TDR);
        tcr_wr   = wr_en & addr_hit & (reg_sel == REG_TCR);
        tsr_wr   = wr_en & addr_hit & (reg_sel == REG_TSR);
    end

    always_comb begin
        rd_data = '0;
        if (apb.PSEL && !apb.PWRITE && addr_hit) begin
            unique case (reg_sel)
                REG_TDR:  rd_data = tdr_q;
                REG_TCR:  rd_data = tcr_q;
                REG_TSR:  rd_data = DATA_WIDTH'({tsr_udf_q, tsr_ovf_q});
                REG_TCNT: rd_data = tcnt_q;
                default:  rd_data = '0;
            endcase
        end
        apb.PRDATA  = rd_data;
        apb.PSLVERR = apb.PSEL & apb.PENABLE & ~addr_hit;
    end

    always_comb begin
        tdr_d        = tdr_wr ? apb.PWDATA : tdr_q;
        tcr_d        = tcr_wr ? (apb.PWDATA & TCR_MASK) : tcr_q;
        load_prev_d  = tcr_q[TCR_LOAD];
        presc_d      = presc_q + 4'd1;
        presc_prev_d = presc_q;

        // Edge detect on the whole prescaler history so switching cks never fakes a tick.
        tick     = presc_q[tcr_q[1:0]] & ~presc_prev_q[tcr_q[1:0]];
        load_req = tdr_wr | (tcr_q[TCR_LOAD] & ~load_prev_q);
        count_go = tick & tcr_q[TCR_EN] & ~tcr_q[TCR_LOAD] & ~load_req;
        ovf_set  = count_go & ~tcr_q[TCR_DIR] & (tcnt_q == '1);
        udf_set  = count_go &  tcr_q[TCR_DIR] & (tcnt_q == '0);

        tcnt_d = tcnt_q;
        if (load_req) begin
            tcnt_d = tdr_d;
        end else if (count_go) begin
            tcnt_d = tcr_q[TCR_DIR] ? tcnt_q - DATA_WIDTH'(1) : tcnt_q + DATA_WIDTH'(1);
        end

        // A set in the same cycle as a write-1-clear leaves the flag set.
        tsr_clr   = tsr_wr ? apb.PWDATA[1:0] : 2'b00;
        tsr_ovf_d = ovf_set | (tsr_ovf_q & ~tsr_clr[0]);
        tsr_udf_d = udf_set | (tsr_udf_q & ~tsr_clr[1]);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tdr_q        <= '0;
            tcr_q        <= '0;
            tcnt_q       <= '0;
            tsr_ovf_q    <= 1'b0;
            tsr_udf_q    <= 1'b0;
            presc_q      <= '0;
            presc_prev_q <= '0;
            load_prev_q  <= 1'b0;
        end else begin
            tdr_q        <= tdr_d;
            tcr_q        <= tcr_d;
            tcnt_q       <= tcnt_d;
            tsr_ovf_q    <= tsr_ovf_d;
            tsr_udf_q    <= tsr_udf_d;
            presc_q      <= presc_d;
            presc_prev_q <= presc_prev_d;
            load_prev_q  <= load_prev_d;
        end
    end

    assign TMR_OVF = tsr_ovf_q;
    assign TMR_URF = tsr_udf_q;
endmodule

// File: tb/tb_timer_top.sv
// Scoreboard bench for timer_top: each APB transfer queues its expected response,
// and a monitor checks PRDATA/PSLVERR/PREADY (and optionally the flag pins) in the access phase.
module tb_timer_top;
    logic clk;
    logic rst;
    logic tmr_ovf;
    logic tmr_urf;

    timer_top_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) apb ();

    timer_top #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .PCLK    (clk),
        .PRESET  (rst),
        .apb     (apb),
        .TMR_OVF (tmr_ovf),
        .TMR_URF (tmr_urf)
    );

    typedef struct {
        string      name;
        logic [7:0] rdata;
        logic       slverr;
        bit         chk_pins;
        logic       ovf;
        logic       urf;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endfunction

    // Monitor: consumes one expectation per access phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (apb.PSEL && apb.PENABLE) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: addr 0x%02h with empty scoreboard", apb.PADDR);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".prdata"}, apb.PRDATA, e.rdata);
                    chk({e.name, ".pslverr"}, {7'd0, apb.PSLVERR}, {7'd0, e.slverr});
                    chk({e.name, ".pready"}, {7'd0, apb.PREADY}, 8'd1);
                    if (e.chk_pins) begin
                        chk({e.name, ".tmr_ovf"}, {7'd0, tmr_ovf}, {7'd0, e.ovf});
                        chk({e.name, ".tmr_urf"}, {7'd0, tmr_urf}, {7'd0, e.urf});
                    end
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the commit edge.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd, input logic exp_err, input bit pins,
                        input logic e_ovf, input logic e_urf, input string name);
        exp_t e;
        e.name = name; e.rdata = exp_rd; e.slverr = exp_err;
        e.chk_pins = pins; e.ovf = e_ovf; e.urf = e_urf;
        exp_q.push_back(e);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(posedge clk); #1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic err, input string name);
        xfer(1'b1, addr, data, 8'h00, err, 1'b0, 1'b0, 1'b0, name);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input logic err, input string name);
        xfer(1'b0, addr, 8'h00, exp, err, 1'b0, 1'b0, 1'b0, name);
    endtask

    task automatic rdp(input logic [7:0] addr, input logic [7:0] exp, input logic e_ovf,
                       input logic e_urf, input string name);
        xfer(1'b0, addr, 8'h00, exp, 1'b0, 1'b1, e_ovf, e_urf, name);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0;  apb.PWDATA = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rdp(8'h00, 8'h00, 1'b0, 1'b0, "rst_tdr");
        rd (8'h01, 8'h00, 1'b0, "rst_tcr");
        rd (8'h02, 8'h00, 1'b0, "rst_tsr");
        rd (8'h03, 8'h00, 1'b0, "rst_tcnt");

        // Unmapped address and read-only TCNT
        wr (8'h7C, 8'h55, 1'b1, "unmap_wr");
        rd (8'h00, 8'h00, 1'b0, "unmap_tdr");
        rd (8'h01, 8'h00, 1'b0, "unmap_tcr");
        rd (8'h02, 8'h00, 1'b0, "unmap_tsr");
        rd (8'h7C, 8'h00, 1'b1, "unmap_rd");
        wr (8'h03, 8'h77, 1'b0, "tcnt_wr");
        rd (8'h03, 8'h00, 1'b0, "tcnt_ro");

        // Register access, TCR mask, TSR clear with nothing set
        wr (8'h00, 8'hA5, 1'b0, "tdr_wr");
        rd (8'h00, 8'hA5, 1'b0, "tdr_rd");
        rd (8'h03, 8'hA5, 1'b0, "tdr_load");
        wr (8'h01, 8'hFF, 1'b0, "tcr_wr");
        rd (8'h01, 8'hB3, 1'b0, "tcr_mask");
        wr (8'h02, 8'hFF, 1'b0, "tsr_wr");
        rd (8'h02, 8'h00, 1'b0, "tsr_empty");
        wr (8'h01, 8'h00, 1'b0, "tcr_clr");
        rd (8'h03, 8'hA5, 1'b0, "tcnt_held");

        // Up-count overflow: enable commit E0, disable commit E4 -> exactly 2 /2 ticks
        wr (8'h00, 8'hFF, 1'b0, "tdr_ff");
        wr (8'h01, 8'h80, 1'b0, "tcr_load");
        wr (8'h01, 8'h00, 1'b0, "tcr_unload");
        rd (8'h03, 8'hFF, 1'b0, "tcnt_ff");
        wr (8'h01, 8'h10, 1'b0, "tcr_up2");
        idle(2);
        wr (8'h01, 8'h00, 1'b0, "tcr_stop1");
        rd (8'h03, 8'h01, 1'b0, "ovf_tcnt");
        rdp(8'h02, 8'h01, 1'b1, 1'b0, "ovf_tsr");
        wr (8'h02, 8'h01, 1'b0, "ovf_clr");
        rdp(8'h02, 8'h00, 1'b0, 1'b0, "ovf_cleared");

        // Down-count underflow: disable commit E2 -> exactly 1 tick
        wr (8'h00, 8'h00, 1'b0, "tdr_00");
        wr (8'h01, 8'h30, 1'b0, "tcr_dn2");
        wr (8'h01, 8'h00, 1'b0, "tcr_stop2");
        rd (8'h03, 8'hFF, 1'b0, "udf_tcnt");
        rdp(8'h02, 8'h02, 1'b0, 1'b1, "udf_tsr");
        wr (8'h02, 8'h02, 1'b0, "udf_clr");
        rdp(8'h02, 8'h00, 1'b0, 1'b0, "udf_cleared");

        // /16 for 160 PCLK edges -> 10 ticks, then reload via TCR.load rising edge
        wr (8'h00, 8'h00, 1'b0, "tdr_00b");
        wr (8'h01, 8'h13, 1'b0, "tcr_up16");
        idle(158);
        wr (8'h01, 8'h00, 1'b0, "tcr_stop3");
        rd (8'h03, 8'h0A, 1'b0, "div16_tcnt");
        rd (8'h02, 8'h00, 1'b0, "div16_tsr");
        wr (8'h01, 8'h80, 1'b0, "tcr_load2");
        rd (8'h03, 8'h00, 1'b0, "load_rise");
        rd (8'h01, 8'h80, 1'b0, "tcr_load_rd");

        // Reset in the middle of counting with OVF set
        wr (8'h00, 8'hFE, 1'b0, "tdr_fe");
        wr (8'h01, 8'h10, 1'b0, "tcr_up2b");
        idle(12);
        rdp(8'h02, 8'h01, 1'b1, 1'b0, "pre_rst_tsr");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdp(8'h00, 8'h00, 1'b0, 1'b0, "mid_rst_tdr");
        rd (8'h01, 8'h00, 1'b0, "mid_rst_tcr");
        rd (8'h02, 8'h00, 1'b0, "mid_rst_tsr");
        rd (8'h03, 8'h00, 1'b0, "mid_rst_tcnt");

        idle(3);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_top.md
Name: timer_top

Overview:
8-bit programmable up/down timer with an APB slave register interface. It has four registers:
- TDR: reload data.
- TCR: control.
- TSR: status.
- TCNT: counter.
A prescaled tick selected in TCR advances TCNT; wrap-around sets sticky overflow/underflow flags that also drive output pins.

Parameters:
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 8, register/data width (counter width)

Ports:
PCLK  input  1  sole clock; all state updates on rising edge
PRESET  input  1  reset; one clock; reset is synchronous and active-high
PSEL  input  1  APB select
PWRITE  input  1  1=write, 0=read
PENABLE  input  1  APB access phase
PADDR  input  ADDR_WIDTH  register address
PWDATA  input  DATA_WIDTH  write data
PRDATA  output  DATA_WIDTH  read data
PREADY  output  1  transfer complete
PSLVERR  output  1  error for unmapped address
TMR_OVF  output  1  overflow flag (= TSR[0])
TMR_URF  output  1  underflow flag (= TSR[1])

Behaviour:
- Address map: TDR=0x00, TCR=0x01, TSR=0x02, TCNT=0x03. All other addresses are unmapped.
- APB transfers:
  - PREADY=1 in every access phase; zero wait states.
  - A write commits on the PCLK edge where PSEL&PENABLE&PWRITE&PREADY.
  - PRDATA is combinational: the register value when PSEL&~PWRITE, else 0. Unmapped reads return 0.
  - PSLVERR = PSEL&PENABLE&unmapped(PADDR), combinational. Unmapped writes change nothing.
- TDR: R/W, full 8 bits.
- TCR: R/W with mask 0xB3; bits 6,3,2 are reserved (write ignored, read 0).
  - bit7 load.
  - bit5 dir (0=up, 1=down).
  - bit4 en.
  - bits1:0 cks.
- TSR:
  - bit0 OVF, bit1 UDF; other bits read 0.
  - Writing 1 to a bit clears it; writing 0 has no effect.
  - A set event in the same cycle as a clear wins (flag stays 1).
- TCNT: read-only; writes are accepted (PSLVERR=0) and ignored.
- Prescaler:
  - Free-running 4-bit counter on PCLK.
  - Counter clock = prescaler bit selected by cks: 00→bit0 (PCLK/2), 01→bit1 (/4), 10→bit2 (/8), 11→bit3 (/16).
  - Tick = one-PCLK pulse on the rising edge of the counter clock, detected with a registered previous-value flop.
- Load:
  - load_req = TDR write pulse, OR rising edge of TCR.load (registered previous value).
  - On the PCLK edge after load_req, TCNT <= TDR (the new value).
  - Load takes priority over counting in that cycle.
  - While TCR.load=1, counting is held.
- Count: on tick with en=1 and load=0, TCNT ±1 per dir, mod 256.
  - Up 0xFF→0x00 sets OVF.
  - Down 0x00→0xFF sets UDF.
- Reset: TDR, TCR, TSR, TCNT, prescaler and edge flops are all 0. PRDATA=0, PSLVERR=0, TMR_OVF=0, TMR_URF=0.
- Reset asserted mid-operation clears everything on the next edge, including any in-progress transfer effects.

Test Plan:
1. Reset, then read all four registers → all 0x00; PSLVERR=0, PREADY=1.
2. Write 0x55 to address 0x7C → PSLVERR=1 in the access phase; TDR/TCR/TSR unchanged. Read 0x7C → PRDATA=0, PSLVERR=1.
3. Write TDR=0xA5 → read TDR=0xA5, TCNT=0xA5. Write TCR=0xFF → read 0xB3. Write TSR=0xFF with no flags set → read 0x00.
4. Write TDR=0xFF, then TCR=0x80 followed by TCR=0x00 → TCNT=0xFF. Write TCR=0x10 (up, /2) → after 2 ticks TCNT=0x01, TSR=0x01, TMR_OVF=1. Write TSR=0x01 → TSR=0x00, TMR_OVF=0.
5. Write TDR=0x00, then TCR=0x30 (down, /2) → after 1 tick TCNT=0xFF, TMR_URF=1, TSR=0x02.
6. Write TDR=0x00, then TCR=0x13 (up, /16) and wait 160 PCLK → TCNT=10 (±1). Assert PRESET for 1 cycle mid-count → all registers and outputs 0 next cycle.
